dram_write_queue: RTL
=====================

# dram_write_queue

Parametrised successor to the scratchpad DRAM write latch. Accepts whole scratchpad rows (data, base DRAM address, per-element column mask, beat count, ID) into a DEPTH-entry row buffer. Serialises each row into BEAT_W-wide DRAM write beats with incrementing addresses and per-beat element masks, honouring backend stall. Sits between the scratchpad read port and the DRAM backend write channel; optionally suppresses beats whose mask is empty.

## Interface
Parameters:
- ROW_W, 512: scratchpad row width in bits (32 elements × 16 b).
- ELEM_W, 16: element width; ROW_W/ELEM_W = NELEM mask bits per row.
- BEAT_W, 64: DRAM beat width; NBEAT = ROW_W/BEAT_W (integer), EPB = BEAT_W/ELEM_W.
- DEPTH, 2: row buffer entries; power of 2, ≥2.
- ADDR_W, 32: DRAM byte address width.
- ID_W, 8: request ID width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- row_valid  in  1  row offered this cycle.
- row_ready  out  1  buffer can accept a row; equals (count < DEPTH) && !RST.
- row_data  in  ROW_W  row payload; beat k = row_data[k*BEAT_W +: BEAT_W].
- row_addr  in  ADDR_W  base byte address of beat 0.
- row_mask  in  NELEM  per-element write enable.
- row_nbeats  in  $clog2(NBEAT)  beats to send minus one (0 → 1 beat).
- row_id  in  ID_W  tag carried onto every beat.
- req_valid  out  1  beat presented.
- req_data  out  BEAT_W  beat payload.
- req_addr  out  ADDR_W  row_addr + k*(BEAT_W/8).
- req_mask  out  EPB  row_mask[k*EPB +: EPB].
- req_id  out  ID_W  row_id of head row.
- req_last  out  1  final beat of the head row.
- req_stall  in  1  backend stall; beat transfers iff req_valid && !req_stall.
- row_done  out  1  one-cycle pulse when head row retires.
- busy  out  1  count != 0.

## Operation
- Push: row_valid && row_ready writes entry at wr_ptr; wr_ptr, count increment. No push-through when full, even if head retires the same cycle.
- Head FSM: IDLE (count==0) → SEND when count≠0. In SEND, beat pointer k indexes head row; on transfer: if req_last, pop (rd_ptr++, count--, k←0, row_done=1), go IDLE if count becomes 0 with no simultaneous push, else remain in SEND with next row; otherwise k advances.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Address arithmetic: modulo 2^ADDR_W, no carry-out or alignment check.
- req_* are driven combinationally from the head entry and k; they are stable while req_valid && req_stall.
- row_nbeats ≥ NBEAT is clamped to NBEAT-1.

## Timing
- Reset (RST high at edge): count, pointers, k ← 0; FSM IDLE; req_valid, row_done, busy, req_last = 0; req_data/addr/mask/id = 0; row_ready = 0 while RST high.
- Row accepted at edge N → req_valid high in cycle N+1 (buffer empty, no stall).
- Unstalled throughput: one beat per cycle, rows back-to-back with no bubble.
- row_done asserted in the cycle after the last beat's transfer edge, for one cycle.
- RST mid-row: in-flight and buffered rows discarded; no row_done.

## Configuration
- DRAM_WQ_SKIP_EMPTY_EN defined: beats with req_mask == 0 are never presented. k jumps (priority encode, same cycle) to the next non-empty beat ≤ nbeats; req_last marks the last non-empty beat. A row with no non-empty beat retires in one cycle at head without req_valid, pulsing row_done.
- Undefined: every beat 0..nbeats presented, including zero-mask beats; req_last on beat nbeats.

## Test plan
- Full row, nbeats=7, addr=0x1000, mask all 1, id=0x5A → 8 beats, addrs 0x1000..0x1038 step 8, req_mask=0xF, req_last on 8th, row_done one cycle later.
- req_stall high 3 cycles during beat 2 → beat 2 data/addr held, no beat lost or duplicated, total 8 transfers.
- Push 3 rows back-to-back, DEPTH=2, stall high → row_ready low after 2 accepted; release stall → 16 beats, no bubble between rows, IDs in order.
- nbeats=0, mask=0x0000000F → single beat, req_last=1 on it, req_mask=0xF.
- SKIP_EMPTY on, mask=0x0000F00F, nbeats=7 → beats k=0,3 only (addrs base, base+24), req_last on k=3; mask=0 → no req_valid, row_done pulse. SKIP_EMPTY off: 8 beats emitted.
- RST asserted mid-row at beat 4 with second row buffered → next cycle req_valid=0, busy=0, row_ready=0 during RST, 1 after; subsequent row starts at k=0.

Source files
------------

// File: rtl/dram_write_queue.sv
//------------------------------------------------------------------------------
// Module      : dram_write_queue
// Description : DEPTH-entry scratchpad row buffer that serialises rows into
//               BEAT_W-wide DRAM write beats with per-beat element masks.
//               Optional build macro: DRAM_WQ_SKIP_EMPTY_EN (drop zero-mask beats).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dram_write_queue #(
    parameter int ROW_W  = 512,
    parameter int ELEM_W = 16,
    parameter int BEAT_W = 64,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              row_valid,
    output logic                              row_ready,
    input  logic [ROW_W-1:0]                  row_data,
    input  logic [ADDR_W-1:0]                 row_addr,
    input  logic [ROW_W/ELEM_W-1:0]           row_mask,
    input  logic [$clog2(ROW_W/BEAT_W)-1:0]   row_nbeats,
    input  logic [ID_W-1:0]                   row_id,
    output logic                              req_valid,
    output logic [BEAT_W-1:0]                 req_data,
    output logic [ADDR_W-1:0]                 req_addr,
    output logic [BEAT_W/ELEM_W-1:0]          req_mask,
    output logic [ID_W-1:0]                   req_id,
    output logic                              req_last,
    input  logic                              req_stall,
    output logic                              row_done,
    output logic                              busy
);

    localparam int NBEAT      = ROW_W / BEAT_W;
    localparam int EPB        = BEAT_W / ELEM_W;
    localparam int K_W        = $clog2(NBEAT);
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam int BEAT_BYTES = BEAT_W / 8;

    typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;
    typedef logic [NBEAT-1:0][BEAT_W-1:0] row_data_t;
    typedef logic [NBEAT-1:0][EPB-1:0]    row_mask_t;

    row_data_t         data_mem   [DEPTH];
    row_mask_t         mask_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem   [DEPTH];
    logic [K_W-1:0]    nbeats_mem [DEPTH];
    logic [ID_W-1:0]   id_mem     [DEPTH];

    state_t            state_q,    state_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [K_W-1:0]    k_q,        k_d;
    logic              row_done_q, row_done_d;

    row_data_t         head_data;
    row_mask_t         head_mask;
    logic [ADDR_W-1:0] head_addr;
    logic [K_W-1:0]    head_nbeats;
    logic [ID_W-1:0]   head_id;
    logic [K_W-1:0]    nbeats_clamped;
    logic [K_W-1:0]    beat_cur;
    logic              beat_found;
    logic              beat_more;
    logic              sending;
    logic              push;
    logic              pop;
    logic              xfer;

    assign row_ready = (count_q < CNT_W'(DEPTH)) && !RST;
    assign push      = row_valid && row_ready;
    assign busy      = (count_q != '0);
    assign row_done  = row_done_q;
    assign sending   = (state_q == ST_SEND);

    assign nbeats_clamped = (row_nbeats > K_W'(NBEAT - 1)) ? K_W'(NBEAT - 1) : row_nbeats;

    assign head_data   = data_mem[rd_ptr_q];
    assign head_mask   = mask_mem[rd_ptr_q];
    assign head_addr   = addr_mem[rd_ptr_q];
    assign head_nbeats = nbeats_mem[rd_ptr_q];
    assign head_id     = id_mem[rd_ptr_q];

    // beat_cur is the beat presented now; beat_more says another beat follows it
    always_comb begin
`ifdef DRAM_WQ_SKIP_EMPTY_EN
        beat_cur   = '0;
        beat_found = 1'b0;
        beat_more  = 1'b0;
        for (int b = 0; b < NBEAT; b++) begin
            if ((int'(k_q) <= b) && (b <= int'(head_nbeats)) && (|head_mask[b])) begin
                if (!beat_found) begin
                    beat_cur   = K_W'(b);
                    beat_found = 1'b1;
                end else begin
                    beat_more = 1'b1;
                end
            end
        end
`else
        beat_cur   = k_q;
        beat_found = 1'b1;
        beat_more  = (k_q != head_nbeats);
`endif
    end

    assign req_valid = sending && beat_found;
    assign xfer      = req_valid && !req_stall;
    // A head row with nothing left to send retires without presenting a beat
    assign pop       = sending && ((xfer && !beat_more) || !beat_found);

    assign req_data = req_valid ? head_data[beat_cur] : '0;
    assign req_mask = req_valid ? head_mask[beat_cur] : '0;
    assign req_addr = req_valid ? (head_addr + ADDR_W'(beat_cur) * ADDR_W'(BEAT_BYTES)) : '0;
    assign req_id   = req_valid ? head_id : '0;
    assign req_last = req_valid && !beat_more;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        k_d = k_q;
        if (pop) begin
            k_d = '0;
        end else if (xfer) begin
            k_d = beat_cur + 1'b1;
        end
        state_d    = (count_d != '0) ? ST_SEND : ST_IDLE;
        row_done_d = pop;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            k_q        <= '0;
            row_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            k_q        <= k_d;
            row_done_q <= row_done_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            data_mem[wr_ptr_q]   <= row_data;
            mask_mem[wr_ptr_q]   <= row_mask;
            addr_mem[wr_ptr_q]   <= row_addr;
            nbeats_mem[wr_ptr_q] <= nbeats_clamped;
            id_mem[wr_ptr_q]     <= row_id;
        end
    end

endmodule

`default_nettype wire
